// File: rtl/product_accumulator.sv
// Frame accumulator: sums N unsigned 4x4 products, holds the result until taken.
// Carry out of the accumulator's MSB is recorded in a sticky per-frame flag.
module pa_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module pa_mul4x4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [3:0] w_pp   [0:3];
    logic [3:0] w_prev [1:3];
    logic [3:0] w_s    [1:3];
    logic [4:0] w_c    [1:3];

    genvar i, j;
    for (i = 0; i < 4; i++) begin : g_pp
        assign w_pp[i] = i_a & {4{i_b[i]}};
    end

    assign o_p[0]    = w_pp[0][0];
    assign w_prev[1] = {1'b0, w_pp[0][3:1]};

    // Ripple array: each row adds the next partial product to the shifted prior row.
    for (i = 1; i < 4; i++) begin : g_row
        assign w_c[i][0] = 1'b0;
        for (j = 0; j < 4; j++) begin : g_col
            pa_fa u_fa (
                .i_a (w_prev[i][j]),
                .i_b (w_pp[i][j]),
                .i_c (w_c[i][j]),
                .o_s (w_s[i][j]),
                .o_c (w_c[i][j+1])
            );
        end
        assign o_p[i] = w_s[i][0];
        if (i < 3) begin : g_next
            assign w_prev[i+1] = {w_c[i][4], w_s[i][3:1]};
        end
    end

    assign o_p[7:4] = {w_c[3][4], w_s[3][3:1]};
endmodule

module product_accumulator #(
    parameter int N     = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             overflow
);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic [7:0]       w_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_in_hs;
    logic             w_out_hs;

    pa_mul4x4 u_mul (
        .i_a (a),
        .i_b (b),
        .o_p (w_prod)
    );

    assign w_prod_ext = ACC_W'(w_prod);
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};

    assign in_ready  = !rst && (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign out_sum   = r_acc;
    assign overflow  = r_ovf;
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_in_hs) begin
                        r_acc   <= w_prod_ext;
                        r_cnt   <= CNT_W'(1);
                        r_ovf   <= 1'b0;
                        r_state <= (N == 1) ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (w_in_hs) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_ovf <= r_ovf | w_sum[ACC_W];
                        if (r_cnt == LAST) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Overflow survives the output handshake until the next frame starts.
                    if (w_out_hs) begin
                        r_state <= IDLE;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
